fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of async_fifo between NUM_REQ independent producers in the w_clk domain. Grants use rotating (round-robin) priority. Each grant lasts up to BURST_LEN accepted words. The block drives w_en/w_data directly into the FIFO and honours full, so no word is ever dropped or duplicated.

---
 rtl/fifo_wr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter feeding async_fifo from NUM_REQ producers in the w_clk domain.
// Optional full-stall statistics counter is built when WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    localparam int GNT_W     = $clog2(NUM_REQ)
) (
    input  logic                          w_clk,
    input  logic                          w_rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [GNT_W-1:0]              gnt_id,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);

    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_r;
    logic [GNT_W-1:0]        gnt_r;
    logic [BW-1:0]           beat_r;
    logic                    busy_r;

    logic                    holder_req_s;
    logic [NUM_REQ-1:0]      one_hot_s;
    logic [DATA_WIDTH-1:0]   holder_data_s;
    logic                    accept_s;
    logic                    last_beat_s;
    logic                    release_s;
    logic                    any_req_s;
    logic [GNT_W-1:0]        win_s;

    // Select the current holder's request, data and one-hot ack pattern.
    always_comb begin
        holder_req_s  = 1'b0;
        holder_data_s = {DATA_WIDTH{1'b0}};
        one_hot_s     = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GNT_W'(i) == gnt_r) begin
                holder_req_s  = req[i];
                holder_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                one_hot_s[i]  = 1'b1;
            end else begin
                one_hot_s[i]  = 1'b0;
            end
        end
    end

    // Rotating-priority search; the holder itself is examined last.
    always_comb begin
        logic             found_v;
        int               idx_v;
        logic [GNT_W-1:0] cand_v;
        found_v   = 1'b0;
        idx_v     = 0;
        cand_v    = {GNT_W{1'b0}};
        win_s     = gnt_r;
        any_req_s = |req;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_v  = int'(gnt_r) + i;
            idx_v  = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
            cand_v = GNT_W'(idx_v);
            if (!found_v && req[cand_v]) begin
                win_s   = cand_v;
                found_v = 1'b1;
            end else begin
                win_s   = win_s;
            end
        end
    end

    // Write-port handshake is combinational so a rising full blocks the write in the same cycle.
    always_comb begin
        accept_s    = (state_r == GRANT) & holder_req_s & ~full & w_rst_n;
        last_beat_s = (beat_r == BW'(BURST_LEN - 1));
        release_s   = (accept_s & last_beat_s) | ~holder_req_s;
        w_en        = accept_s;
        ack         = accept_s ? one_hot_s : {NUM_REQ{1'b0}};
        if (state_r == GRANT) begin
            w_data = holder_data_s;
        end else begin
            w_data = {DATA_WIDTH{1'b0}};
        end
    end

    // Grant FSM with burst counting; full holds the grant without consuming a beat.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_r <= IDLE;
            gnt_r   <= GNT_W'(NUM_REQ - 1);
            beat_r  <= {BW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r <= GRANT;
                        gnt_r   <= win_s;
                        beat_r  <= {BW{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        if (any_req_s) begin
                            gnt_r  <= win_s;
                            beat_r <= {BW{1'b0}};
                            busy_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            beat_r  <= {BW{1'b0}};
                            busy_r  <= 1'b0;
                        end
                    end else if (accept_s) begin
                        beat_r <= beat_r + BW'(1);
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    beat_r  <= {BW{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_id = gnt_r;
    assign busy   = busy_r;

`ifdef WR_ARB_STATS_EN
    logic [15:0] stall_r;

    // Saturating count of cycles where the holder is blocked by full.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            stall_r <= 16'h0000;
        end else if ((state_r == GRANT) && holder_req_s && full && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'h0001;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cnt = stall_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer models, a behavioural FIFO fill model and per-scenario tasks.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            full = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic            w_en;
    logic [DW-1:0]   w_data;
    logic [1:0]      gnt_id;
    logic            busy;
    logic [15:0]     stall_cnt;

    int errors = 0;
    int checks = 0;

    int         left [N];
    int         word [N];
    logic [7:0] base [N];
    logic [N-1:0] ack_s = '0;

    logic [9:0] sb_q [$];
    logic [7:0] fifo_q [$];
    bit         fifo_mode = 1'b0;
    int         fifo_cnt = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .w_clk(clk), .w_rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .full(full), .w_en(w_en), .w_data(w_data), .gnt_id(gnt_id), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard: every write must match the next expected {id,data}; no ack without a write.
    always @(negedge clk) begin
        logic [9:0] exp;
        logic [3:0] one;
        one = 4'b0001;
        if (w_en === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data=%h id=%0d, required no write", w_data, gnt_id);
            end else begin
                exp = sb_q.pop_front();
                if (w_data !== exp[7:0] || gnt_id !== exp[9:8] || ack !== (one << exp[9:8])) begin
                    errors++;
                    $display("FAIL write_order: got data=%h id=%0d ack=%b, required data=%h id=%0d",
                             w_data, gnt_id, ack, exp[7:0], exp[9:8]);
                end
            end
            if (fifo_mode) begin
                fifo_q.push_back(w_data);
                fifo_cnt++;
            end
        end else begin
            checks++;
            if (ack !== 4'b0000) begin
                errors++;
                $display("FAIL ack_without_wen: got ack=%b w_en=%b, required ack=0000", ack, w_en);
            end
        end
    end

    task automatic apply_drive();
        for (int i = 0; i < N; i++) begin
            if (ack_s[i] && req[i]) begin
                word[i]++;
                left[i]--;
            end
            req[i] = (left[i] > 0);
            req_data[i*DW +: DW] = base[i] + 8'(word[i]);
        end
        ack_s = '0;
        if (fifo_mode) full = (fifo_cnt >= 16);
    endtask

    task automatic tick();
        @(negedge clk);
        ack_s = ack;
        @(posedge clk);
        #1;
        apply_drive();
    endtask

    task automatic set_req(input int i, input logic [7:0] b, input int n);
        base[i] = b;
        word[i] = 0;
        left[i] = n;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        sb_q.push_back({2'(id), d});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 8'(i * 16), 1);
        apply_drive();
        repeat (3) begin
            tick();
            #2;
            checks++;
            if (w_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd3 || stall_cnt !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state: got w_en=%b ack=%b busy=%b gnt=%0d stall=%0d, required 0,0000,0,3,0",
                         w_en, ack, busy, gnt_id, stall_cnt);
            end
        end
        for (int i = 0; i < N; i++) push(i, 8'(i * 16));
        rst_n = 1'b1;
        #1;
        checks++;
        if (w_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got w_en=%b busy=%b, required 0,0", w_en, busy);
        end
        tick();
        #2;
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: got ack=%b busy=%b, required 0001,1", ack, busy);
        end
        drain("reset");
    endtask

    task automatic test_single();
        set_req(1, 8'h10, 6);
        for (int k = 0; k < 6; k++) push(1, 8'(8'h10 + k));
        tick();
        #2;
        checks++;
        if (w_en !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got w_en=%b, required 0", w_en);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            #2;
            checks++;
            if (w_en !== 1'b1) begin
                errors++;
                $display("FAIL single_stream_%0d: got w_en=%b, required 1", k, w_en);
            end
        end
        drain("single");
    endtask

    task automatic test_fairness();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 8'(i * 16), 8);
        tick();
        tick();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                for (int w = 0; w < 4; w++)
                    push(i, 8'(i * 16 + r * 4 + w));
        rst_n = 1'b1;
        drain("fairness");
    endtask

    task automatic test_full_stall();
        logic [15:0] exp_stall;
        set_req(2, 8'h20, 4);
        push(2, 8'h20);
        push(2, 8'h21);
        tick();
        tick();
        tick();
        set_req(3, 8'h30, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            full = 1'b1;
            #2;
            checks++;
            if (w_en !== 1'b0 || ack !== 4'b0000 || gnt_id !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold_%0d: got w_en=%b ack=%b gnt=%0d, required 0,0000,2", k, w_en, ack, gnt_id);
            end
        end
        push(2, 8'h22);
        push(2, 8'h23);
        push(3, 8'h30);
        tick();
        full = 1'b0;
        #2;
        checks++;
        if (w_en !== 1'b1 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL stall_resume: got w_en=%b gnt=%0d, required 1,2", w_en, gnt_id);
        end
        tick();
        tick();
        #2;
        checks++;
        if (gnt_id !== 2'd3 || ack !== 4'b1000) begin
            errors++;
            $display("FAIL stall_rotate: got gnt=%0d ack=%b, required 3,1000", gnt_id, ack);
        end
`ifdef WR_ARB_STATS_EN
        exp_stall = 16'd3;
`else
        exp_stall = 16'd0;
`endif
        checks++;
        if (stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, required %0d", stall_cnt, exp_stall);
        end
        drain("stall");
    endtask

    task automatic test_early_release();
        set_req(0, 8'h00, 1);
        set_req(3, 8'h30, 1);
        push(0, 8'h00);
        push(3, 8'h30);
        tick();
        tick();
        #2;
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL early_first: got ack=%b, required 0001", ack);
        end
        tick();
        #2;
        checks++;
        if (w_en !== 1'b0) begin
            errors++;
            $display("FAIL early_release_cycle: got w_en=%b, required 0", w_en);
        end
        tick();
        #2;
        checks++;
        if (gnt_id !== 2'd3 || ack !== 4'b1000) begin
            errors++;
            $display("FAIL early_regrant: got gnt=%0d ack=%b, required 3,1000", gnt_id, ack);
        end
        drain("early");
    endtask

    task automatic test_reset_fifo();
        set_req(1, 8'h40, 8);
        push(1, 8'h40);
        push(1, 8'h41);
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if (w_en !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL midburst_reset: got w_en=%b ack=%b, required 0,0000", w_en, ack);
        end
        set_req(1, 8'h40, 0);
        set_req(0, 8'h50, 1);
        set_req(2, 8'h60, 1);
        push(0, 8'h50);
        push(2, 8'h60);
        tick();
        #2;
        checks++;
        if (busy !== 1'b0 || gnt_id !== 2'd3 || w_en !== 1'b0) begin
            errors++;
            $display("FAIL midburst_idle: got busy=%b gnt=%0d w_en=%b, required 0,3,0", busy, gnt_id, w_en);
        end
        rst_n = 1'b1;
        tick();
        #2;
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL priority_restart: got ack=%b, required 0001", ack);
        end
        drain("restart");

        fifo_cnt = 0;
        fifo_q.delete();
        fifo_mode = 1'b1;
        set_req(0, 8'h80, 20);
        for (int k = 0; k < 16; k++) push(0, 8'(8'h80 + k));
        drain("fifo_fill");
        repeat (6) begin
            tick();
            #2;
            checks++;
            if (ack !== 4'b0000 || w_en !== 1'b0 || gnt_id !== 2'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL full_hold: got ack=%b w_en=%b gnt=%0d busy=%b, required 0000,0,0,1",
                         ack, w_en, gnt_id, busy);
            end
        end
        checks++;
        if (fifo_q.size() != 16) begin
            errors++;
            $display("FAIL fifo_count: got %0d, required 16", fifo_q.size());
        end
        for (int k = 0; k < 16 && fifo_q.size() != 0; k++) begin
            logic [7:0] got;
            got = fifo_q.pop_front();
            checks++;
            if (got !== 8'(8'h80 + k)) begin
                errors++;
                $display("FAIL fifo_readout_%0d: got %h, required %h", k, got, 8'(8'h80 + k));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            word[i] = 0;
            base[i] = 8'h00;
        end
        test_reset();
        test_single();
        test_fairness();
        test_full_stall();
        test_early_release();
        test_reset_fifo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
